dmem_bist: RTL and testbench

Built-in self-test initiator for the data memory. Drives the same read/write port set the pipelined CPU uses (8-bit addresses, 32-bit data) and runs a four-phase march test over the memory. It reports pass/fail and the first failing address and data. It sits beside the CPU in the top level, with a mux selecting which initiator owns the memory ports.

---
 rtl/dmem_bist_pkg.sv | 31 +++
 rtl/dmem_bist_addr_gen.sv | 59 +++++
 rtl/dmem_bist.sv | 251 +++++++++++++++++++++++++
 tb/tb_dmem_bist.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_bist_pkg.sv
// dmem_bist_pkg: shared state encoding, memory widths and the march pattern
// helper used by the data-memory BIST initiator.
package dmem_bist_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 32;

  localparam logic [31:0] PATTERN_BASE = 32'hA5A5_A5A5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_W0    = 3'd1,
    ST_RW_UP = 3'd2,
    ST_RW_DN = 3'd3,
    ST_R_UP  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // P(a) = base XOR zero-extended address; invert selects ~P(a).
  function automatic logic [31:0] pattern(input logic [31:0] addr, input logic invert);
    logic [31:0] p;
    p = PATTERN_BASE ^ addr;
    if (invert) begin
      p = ~p;
    end else begin
      p = p;
    end
    return p;
  endfunction

endpackage

// File: rtl/dmem_bist_addr_gen.sv
// dmem_bist_addr_gen: up/down address counter for the march phases. A load
// has priority over a step; last_o flags the final address of the current
// direction (DEPTH-1 going up, 0 going down). addr_next_o exposes the value
// the counter takes on the coming edge so the parent can register outputs.
module dmem_bist_addr_gen import dmem_bist_pkg::*; #(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_val_i,
  input  logic              step_i,
  input  logic              up_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [ADDR_W-1:0] addr_next_o,
  output logic              last_o
);

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_MAX  = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;

  // Next address: hold when disabled, else load, else step in the given direction.
  always_comb begin
    addr_d = addr_q;
    if (!en_i) begin
      addr_d = addr_q;
    end else if (load_i) begin
      addr_d = load_val_i;
    end else if (step_i) begin
      if (up_i) begin
        addr_d = addr_q + ADDR_ONE;
      end else begin
        addr_d = addr_q - ADDR_ONE;
      end
    end else begin
      addr_d = addr_q;
    end
  end

  // Address register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= ADDR_ZERO;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o      = addr_q;
  assign addr_next_o = addr_d;
  assign last_o      = up_i ? (addr_q == ADDR_MAX) : (addr_q == ADDR_ZERO);

endmodule

// File: rtl/dmem_bist.sv
// dmem_bist: march-test initiator for the data memory (W0 up, RW up,
// RW down, R up). All memory-port and status outputs are registered.
// Optional feature macro: DMEM_BIST_STOP_ON_FAIL_EN -- when defined, the
// first mismatch ends the test immediately in DONE.
module dmem_bist import dmem_bist_pkg::*; #(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_enable,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_mem_read_data,
  output logic [ADDR_W-1:0] o_mem_read_address,
  output logic [ADDR_W-1:0] o_mem_write_address,
  output logic [DATA_W-1:0] o_mem_write_data,
  output logic              o_mem_write_enable,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic [ADDR_W-1:0] o_fail_address,
  output logic [DATA_W-1:0] o_fail_data
);

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

`ifdef DMEM_BIST_STOP_ON_FAIL_EN
  localparam logic STOP_ON_FAIL = 1'b1;
`else
  localparam logic STOP_ON_FAIL = 1'b0;
`endif

  state_e            state_q, state_d;
  logic              cmp_q, cmp_d;         // 0: read cycle, 1: compare cycle
  logic              pass_q, pass_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0] fail_data_q, fail_data_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              ag_load_s;
  logic [ADDR_W-1:0] ag_load_val_s;
  logic              ag_step_s;
  logic              ag_up_s;
  logic [ADDR_W-1:0] addr_s;
  logic [ADDR_W-1:0] addr_next_s;
  logic              ag_last_s;
  logic [DATA_W-1:0] exp_data_s;
  logic              check_phase_s;
  logic              mismatch_s;

  // Pattern sized to the data bus.
  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a, input logic inv);
    return DATA_W'(pattern(32'(a), inv));
  endfunction

  dmem_bist_addr_gen #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_addr_gen (
    .clk         (clk),
    .reset       (reset),
    .en_i        (clk_enable),
    .load_i      (ag_load_s),
    .load_val_i  (ag_load_val_s),
    .step_i      (ag_step_s),
    .up_i        (ag_up_s),
    .addr_o      (addr_s),
    .addr_next_o (addr_next_s),
    .last_o      (ag_last_s)
  );

  assign ag_up_s       = (state_q != ST_RW_DN);
  assign exp_data_s    = pat(addr_s, state_q == ST_RW_DN);
  assign check_phase_s = (state_q == ST_RW_UP) || (state_q == ST_RW_DN) || (state_q == ST_R_UP);
  assign mismatch_s    = check_phase_s && cmp_q && (i_mem_read_data != exp_data_s);

  // Next state, address-generator control and first-failure capture.
  always_comb begin
    state_d       = state_q;
    cmp_d         = cmp_q;
    pass_d        = pass_q;
    fail_addr_d   = fail_addr_q;
    fail_data_d   = fail_data_q;
    ag_load_s     = 1'b0;
    ag_load_val_s = ADDR_ZERO;
    ag_step_s     = 1'b0;
    if (!clk_enable) begin
      state_d = state_q;
    end else begin
      // Only the first mismatch is captured; pass_q low marks it as taken.
      if (mismatch_s && pass_q) begin
        pass_d      = 1'b0;
        fail_addr_d = addr_s;
        fail_data_d = i_mem_read_data;
      end else begin
        pass_d = pass_q;
      end

      if (STOP_ON_FAIL && mismatch_s) begin
        state_d   = ST_DONE;
        cmp_d     = 1'b0;
        ag_load_s = 1'b1;
      end else begin
        case (state_q)
          ST_IDLE, ST_DONE: begin
            if (i_start) begin
              state_d     = ST_W0;
              cmp_d       = 1'b0;
              ag_load_s   = 1'b1;
              pass_d      = 1'b1;
              fail_addr_d = ADDR_ZERO;
              fail_data_d = DATA_ZERO;
            end else begin
              state_d = state_q;
            end
          end
          ST_W0: begin
            if (ag_last_s) begin
              state_d   = ST_RW_UP;
              ag_load_s = 1'b1;
            end else begin
              ag_step_s = 1'b1;
            end
          end
          ST_RW_UP, ST_RW_DN, ST_R_UP: begin
            if (!cmp_q) begin
              cmp_d = 1'b1;
            end else begin
              cmp_d = 1'b0;
              if (ag_last_s) begin
                ag_load_s = 1'b1;
                if (state_q == ST_RW_UP) begin
                  state_d       = ST_RW_DN;
                  ag_load_val_s = ADDR_LAST;
                end else if (state_q == ST_RW_DN) begin
                  state_d = ST_R_UP;
                end else begin
                  state_d = ST_DONE;
                end
              end else begin
                ag_step_s = 1'b1;
              end
            end
          end
          default: begin
            state_d = ST_IDLE;
            cmp_d   = 1'b0;
          end
        endcase
      end
    end
  end

  // Memory-port and status values for the cycle after the coming edge.
  always_comb begin
    raddr_d = ADDR_ZERO;
    waddr_d = ADDR_ZERO;
    wdata_d = DATA_ZERO;
    we_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_d)
      ST_W0: begin
        raddr_d = addr_next_s;
        waddr_d = addr_next_s;
        wdata_d = pat(addr_next_s, 1'b0);
        we_d    = 1'b1;
        busy_d  = 1'b1;
      end
      ST_RW_UP, ST_RW_DN: begin
        raddr_d = addr_next_s;
        busy_d  = 1'b1;
        if (cmp_d) begin
          waddr_d = addr_next_s;
          wdata_d = pat(addr_next_s, state_d == ST_RW_UP);
          we_d    = 1'b1;
        end else begin
          we_d = 1'b0;
        end
      end
      ST_R_UP: begin
        raddr_d = addr_next_s;
        busy_d  = 1'b1;
      end
      ST_DONE: begin
        done_d = 1'b1;
      end
      ST_IDLE: begin
        done_d = 1'b0;
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  // FSM state and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cmp_q       <= 1'b0;
      pass_q      <= 1'b0;
      fail_addr_q <= ADDR_ZERO;
      fail_data_q <= DATA_ZERO;
    end else begin
      state_q     <= state_d;
      cmp_q       <= cmp_d;
      pass_q      <= pass_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
    end
  end

  // Output registers; held while clk_enable is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      raddr_q <= ADDR_ZERO;
      waddr_q <= ADDR_ZERO;
      wdata_q <= DATA_ZERO;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (clk_enable) begin
      raddr_q <= raddr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_mem_read_address  = raddr_q;
  assign o_mem_write_address = waddr_q;
  assign o_mem_write_data    = wdata_q;
  assign o_mem_write_enable  = we_q;
  assign o_busy              = busy_q;
  assign o_done              = done_q;
  assign o_pass              = pass_q;
  assign o_fail_address      = fail_addr_q;
  assign o_fail_data         = fail_data_q;

endmodule

// File: tb/tb_dmem_bist.sv
// tb_dmem_bist: directed bench for dmem_bist with DEPTH=16 and a behavioural
// memory (1-cycle registered read, gated by clk_enable like the CPU side),
// with an optional stuck-at-0 fault on bit 0 of address 5.
module tb_dmem_bist;

  localparam int DEPTH = 16;

`ifdef DMEM_BIST_STOP_ON_FAIL_EN
  localparam int FAULT_DONE_EDGE = 70;
  localparam int FAULT_WRITES    = 43;
`else
  localparam int FAULT_DONE_EDGE = 112;
  localparam int FAULT_WRITES    = 48;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic        i_start;
  logic [31:0] i_mem_read_data;
  logic [7:0]  o_mem_read_address;
  logic [7:0]  o_mem_write_address;
  logic [31:0] o_mem_write_data;
  logic        o_mem_write_enable;
  logic        o_busy;
  logic        o_done;
  logic        o_pass;
  logic [7:0]  o_fail_address;
  logic [31:0] o_fail_data;

  logic [31:0] mem [0:255];
  logic        fault_en;
  int          wr_cnt = 0;
  int          wr_base;
  int          edges;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  dmem_bist #(.ADDR_W(8), .DATA_W(32), .DEPTH(DEPTH)) dut (
    .clk                 (clk),
    .reset               (reset),
    .clk_enable          (clk_enable),
    .i_start             (i_start),
    .i_mem_read_data     (i_mem_read_data),
    .o_mem_read_address  (o_mem_read_address),
    .o_mem_write_address (o_mem_write_address),
    .o_mem_write_data    (o_mem_write_data),
    .o_mem_write_enable  (o_mem_write_enable),
    .o_busy              (o_busy),
    .o_done              (o_done),
    .o_pass              (o_pass),
    .o_fail_address      (o_fail_address),
    .o_fail_data         (o_fail_data)
  );

  // Memory model: registered read, optional stuck-at-0 on bit 0 of word 5.
  always @(posedge clk) begin
    if (clk_enable) begin
      if (o_mem_write_enable) begin
        if (fault_en && o_mem_write_address == 8'd5)
          mem[o_mem_write_address] <= o_mem_write_data & 32'hFFFF_FFFE;
        else
          mem[o_mem_write_address] <= o_mem_write_data;
      end
      i_mem_read_data <= mem[o_mem_read_address];
    end
  end

  // Count write strobes taken by the memory.
  always @(posedge clk) begin
    if (!reset && clk_enable && o_mem_write_enable) wr_cnt <= wr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    edges++;
  endtask

  task automatic run_to(input int n);
    while (edges < n) step();
  endtask

  // Start pulse; the sampling edge becomes edge 0.
  task automatic pulse_start();
    i_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_start = 1'b0;
    edges   = 0;
    wr_base = wr_cnt;
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit && o_done !== 1'b1; i++) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},    {31'd0, o_mem_write_enable}, 32'd0);
    check({tag, "_raddr"}, {24'd0, o_mem_read_address}, 32'd0);
    check({tag, "_waddr"}, {24'd0, o_mem_write_address}, 32'd0);
    check({tag, "_wdata"}, o_mem_write_data, 32'd0);
    check({tag, "_busy"},  {31'd0, o_busy}, 32'd0);
    check({tag, "_done"},  {31'd0, o_done}, 32'd0);
    check({tag, "_pass"},  {31'd0, o_pass}, 32'd0);
    check({tag, "_faddr"}, {24'd0, o_fail_address}, 32'd0);
    check({tag, "_fdata"}, o_fail_data, 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    clk_enable = 1'b1;
    i_start    = 1'b0;
    fault_en   = 1'b0;
    edges      = 0;
    wr_base    = 0;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;
    step();
    check("idle_busy", {31'd0, o_busy}, 32'd0);

    // Clean run.
    pulse_start();
    check("w0_busy",   {31'd0, o_busy}, 32'd1);
    check("w0_done",   {31'd0, o_done}, 32'd0);
    check("w0_we",     {31'd0, o_mem_write_enable}, 32'd1);
    check("w0_wa0",    {24'd0, o_mem_write_address}, 32'd0);
    check("w0_wd0",    o_mem_write_data, 32'hA5A5_A5A5);
    run_to(1);
    check("w0_wa1",    {24'd0, o_mem_write_address}, 32'd1);
    check("w0_wd1",    o_mem_write_data, 32'hA5A5_A5A4);
    run_to(16);
    check("rwup_rd_we", {31'd0, o_mem_write_enable}, 32'd0);
    check("rwup_ra0",   {24'd0, o_mem_read_address}, 32'd0);
    run_to(17);
    check("rwup_cmp_we", {31'd0, o_mem_write_enable}, 32'd1);
    check("rwup_wa0",    {24'd0, o_mem_write_address}, 32'd0);
    check("rwup_wd0",    o_mem_write_data, 32'h5A5A_5A5A);
    run_to(48);
    check("rwdn_ra15",  {24'd0, o_mem_read_address}, 32'd15);
    check("rwdn_rd_we", {31'd0, o_mem_write_enable}, 32'd0);
    run_to(49);
    check("rwdn_wa15",  {24'd0, o_mem_write_address}, 32'd15);
    check("rwdn_wd15",  o_mem_write_data, 32'hA5A5_A5AA);
    run_to(111);
    check("clean_done_early", {31'd0, o_done}, 32'd0);
    check("clean_busy_early", {31'd0, o_busy}, 32'd1);
    run_to(112);
    check("clean_done", {31'd0, o_done}, 32'd1);
    check("clean_busy", {31'd0, o_busy}, 32'd0);
    check("clean_pass", {31'd0, o_pass}, 32'd1);
    check("clean_writes", wr_cnt - wr_base, 32'd48);
    check("clean_mem3", mem[3], 32'hA5A5_A5A6);

    // Stuck-at-0 on bit 0 of address 5.
    fault_en = 1'b1;
    pulse_start();
    wait_done(300);
    check("fault_done",  {31'd0, o_done}, 32'd1);
    check("fault_edge",  edges, FAULT_DONE_EDGE);
    check("fault_pass",  {31'd0, o_pass}, 32'd0);
    check("fault_addr",  {24'd0, o_fail_address}, 32'd5);
    check("fault_data",  o_fail_data, 32'h5A5A_5A5E);
    repeat (20) step();
    check("fault_writes", wr_cnt - wr_base, FAULT_WRITES);
    check("fault_done_held", {31'd0, o_done}, 32'd1);

    // Restart clears results; then reset mid-RW_UP.
    fault_en = 1'b0;
    pulse_start();
    check("restart_pass",  {31'd0, o_pass}, 32'd1);
    check("restart_faddr", {24'd0, o_fail_address}, 32'd0);
    check("restart_fdata", o_fail_data, 32'd0);
    check("restart_done",  {31'd0, o_done}, 32'd0);
    run_to(19);
    check("pre_rst_we", {31'd0, o_mem_write_enable}, 32'd1);
    check("pre_rst_wa", {24'd0, o_mem_write_address}, 32'd1);
    check("pre_rst_wd", o_mem_write_data, 32'h5A5A_5A5B);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    step();
    reset = 1'b0;
    step();
    check_reset_outputs("post_rst");

    // clk_enable low for 10 cycles in RW_DN.
    pulse_start();
    run_to(55);
    check("ce_we", {31'd0, o_mem_write_enable}, 32'd1);
    check("ce_wa", {24'd0, o_mem_write_address}, 32'd12);
    clk_enable = 1'b0;
    repeat (10) step();
    check("frz_we",   {31'd0, o_mem_write_enable}, 32'd1);
    check("frz_wa",   {24'd0, o_mem_write_address}, 32'd12);
    check("frz_ra",   {24'd0, o_mem_read_address}, 32'd12);
    check("frz_wd",   o_mem_write_data, 32'hA5A5_A5A9);
    check("frz_busy", {31'd0, o_busy}, 32'd1);
    clk_enable = 1'b1;
    run_to(121);
    check("ce_done_early", {31'd0, o_done}, 32'd0);
    run_to(122);
    check("ce_done", {31'd0, o_done}, 32'd1);
    check("ce_pass", {31'd0, o_pass}, 32'd1);

    // Start during W0 is ignored.
    pulse_start();
    run_to(3);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    check("w0_start_wa",   {24'd0, o_mem_write_address}, 32'd4);
    check("w0_start_busy", {31'd0, o_busy}, 32'd1);
    wait_done(300);
    check("w0_start_edge", edges, 112);
    check("w0_start_pass", {31'd0, o_pass}, 32'd1);

    // Restart from DONE; start on the final compare edge is ignored.
    pulse_start();
    check("rs_done", {31'd0, o_done}, 32'd0);
    check("rs_busy", {31'd0, o_busy}, 32'd1);
    check("rs_wa",   {24'd0, o_mem_write_address}, 32'd0);
    run_to(111);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    check("final_start_done", {31'd0, o_done}, 32'd1);
    check("final_start_busy", {31'd0, o_busy}, 32'd0);
    check("final_start_pass", {31'd0, o_pass}, 32'd1);
    step();
    check("final_start_held", {31'd0, o_done}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
